note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Playback controller for the music player datapath. It walks the song's phrase-address space and fetches each phrase-id and phrase record from the existing ROMs. It then issues notes one at a time to the tone generator over a valid/ready handshake, and times each note with a tick countdown. It replaces the free-running 4-phase counter_cycle sequencing with an explicit FSM that adds play/pause and a song-wrap indication.

Parameters:
LAST_ADDR, 255, final phrase address; the address wraps to 0 after it
T16, 326, ticks for a short note in bank 1
T8, 652, ticks for a long note in bank 1 and a short note in bank 0
T4, 1304, ticks for a long note in bank 0

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause at next note boundary
tick_en  in  1  one-cycle tick strobe (~12 kHz)
phrase_addr  out  8  address to phrase-id ROM (combinational ROM)
phrase_id  in  5  phrase-id ROM data; [4] = bank, [3:0] = id
rom_phrase_id  out  4  address to both phrase ROMs
bank  out  1  registered phrase_id[4]; selects phrase ROM and freq ROM
phrase_data  in  32  8 nibble freq addresses; note 0 = [31:28]
length_bits  in  8  per-note length flag; note 0 = [7]
n_notes  in  3  notes in phrase minus one
note_valid  out  1  note offer to tone generator
note_ready  in  1  tone generator accepts note
note_freq_addr  out  4  freq ROM address of offered note
note_ticks  out  12  duration of offered note
busy  out  1  high in every state except IDLE and PAUSE
song_wrap  out  1  one-cycle pulse when phrase_addr wraps LAST_ADDR->0

Behaviour:
- Reset values (next clk after reset=1, from any state): state=IDLE, phrase_addr=0, rom_phrase_id=0, bank=0, note_valid=0, note_freq_addr=0, note_ticks=0, busy=0, song_wrap=0. Internal note_idx=0, notes_left=0, tick_cnt=0.
- States: IDLE, FETCH_ID, FETCH_PH, ISSUE, HOLD, PAUSE.
- IDLE: play=1 -> FETCH_ID.
- FETCH_ID (1 cycle): rom_phrase_id<=phrase_id[3:0], bank<=phrase_id[4] -> FETCH_PH.
- FETCH_PH (1 cycle): latch phrase_data, length_bits, and n_notes into notes_left; note_idx<=0 -> ISSUE.
- ISSUE: note_valid=1. note_freq_addr=phrase_reg[31-4*note_idx -: 4]. Length flag L=len_reg[7-note_idx]. note_ticks = bank0 ? (L?T4:T8) : (L?T16... no: L?T8:T16).
  - Outputs stay stable while note_valid=1 and note_ready=0.
  - Accept when note_valid&note_ready: tick_cnt<=note_ticks, note_valid<=0 next cycle -> HOLD.
  - play is ignored in ISSUE; an offered note is never withdrawn.
- HOLD: tick_cnt decrements on each tick_en. When tick_cnt==1 and tick_en=1, the note ends:
  - notes_left!=0: notes_left--, note_idx++. play=1 -> ISSUE; play=0 -> PAUSE.
  - notes_left==0: phrase_addr<=(phrase_addr==LAST_ADDR)?0:phrase_addr+1. On wrap, song_wrap=1 for that cycle. play=1 -> FETCH_ID; play=0 -> IDLE.
- PAUSE: all registers held, busy=0; play=1 -> ISSUE with the same note_idx.
- Latency: play rising in IDLE -> note_valid high 3 cycles later (IDLE, FETCH_ID, FETCH_PH, ISSUE).
- Gap from last tick of a note to the next note_valid: 1 cycle within a phrase, 3 cycles across phrases.
- tick_en during FETCH_ID, FETCH_PH, ISSUE, PAUSE, or IDLE is ignored.
- n_notes=0 gives a 1-note phrase; n_notes=7 gives 8 notes.
- Reset asserted in any state overrides all other events; a pending note is dropped.

Test Plan:
- Reset, then play=1, phrase_id=5'h03, phrase_data=32'h1234_5678, length_bits=8'h80, n_notes=7, note_ready=1 -> rom_phrase_id=3 and bank=0; first note_freq_addr=1 with note_ticks=1304; notes 2..8 give 2..8 with note_ticks=652 each.
- Same phrase but phrase_id=5'h12, length_bits=8'h01 -> bank=1; notes 1..7 have note_ticks=326; note 8 has note_ticks=652; rom_phrase_id=2.
- Hold note_ready=0 for 10 cycles in ISSUE -> note_valid stays 1 with note_freq_addr unchanged; no tick counting; accept on cycle 11.
- Drop play mid-phrase after note 3 ends -> PAUSE with busy=0; play=1 -> note 4 offered (freq addr 4), phrase_addr unchanged.
- Force phrase_addr=255 with n_notes=0 -> after the note ends, phrase_addr=0 and song_wrap pulses exactly 1 cycle.
- Assert reset during HOLD with tick_cnt=400 -> next cycle all outputs at reset values and state IDLE; play=1 restarts at phrase_addr 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Playback controller: walks phrase addresses, fetches phrase records from the ROMs and
// issues timed notes to the tone generator over a valid/ready handshake.
module note_sequencer #(
  parameter int unsigned LAST_ADDR = 255,
  parameter int unsigned T16       = 326,
  parameter int unsigned T8        = 652,
  parameter int unsigned T4        = 1304
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        tick_en,
  output logic [7:0]  phrase_addr,
  input  logic [4:0]  phrase_id,
  output logic [3:0]  rom_phrase_id,
  output logic        bank,
  input  logic [31:0] phrase_data,
  input  logic [7:0]  length_bits,
  input  logic [2:0]  n_notes,
  output logic        note_valid,
  input  logic        note_ready,
  output logic [3:0]  note_freq_addr,
  output logic [11:0] note_ticks,
  output logic        busy,
  output logic        song_wrap
);

  localparam logic [7:0]  LastAddrW = 8'(LAST_ADDR);
  localparam logic [11:0] T16W      = 12'(T16);
  localparam logic [11:0] T8W       = 12'(T8);
  localparam logic [11:0] T4W       = 12'(T4);

  typedef enum logic [2:0] {
    StIdle,
    StFetchId,
    StFetchPh,
    StIssue,
    StHold,
    StPause
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  rom_id_q, rom_id_d;
  logic        bank_q, bank_d;
  logic [31:0] phrase_q, phrase_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  notes_left_q, notes_left_d;
  logic [2:0]  note_idx_q, note_idx_d;
  logic [11:0] tick_cnt_q, tick_cnt_d;
  logic        wrap_q, wrap_d;

  logic [31:0] phrase_sh;
  logic [7:0]  len_sh;
  logic [3:0]  cur_freq;
  logic        cur_long;
  logic [11:0] cur_ticks;

  // Note 0 sits in the top nibble / top bit, so shift the current note to the top.
  always_comb begin
    phrase_sh = phrase_q << {note_idx_q, 2'b00};
    len_sh    = len_q << note_idx_q;
    cur_freq  = phrase_sh[31:28];
    cur_long  = len_sh[7];
    if (bank_q) begin
      cur_ticks = cur_long ? T8W : T16W;
    end else begin
      cur_ticks = cur_long ? T4W : T8W;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rom_id_d     = rom_id_q;
    bank_d       = bank_q;
    phrase_d     = phrase_q;
    len_d        = len_q;
    notes_left_d = notes_left_q;
    note_idx_d   = note_idx_q;
    tick_cnt_d   = tick_cnt_q;
    wrap_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (play) state_d = StFetchId;
      end
      StFetchId: begin
        rom_id_d = phrase_id[3:0];
        bank_d   = phrase_id[4];
        state_d  = StFetchPh;
      end
      StFetchPh: begin
        phrase_d     = phrase_data;
        len_d        = length_bits;
        notes_left_d = n_notes;
        note_idx_d   = 3'd0;
        state_d      = StIssue;
      end
      StIssue: begin
        // play is not sampled here: an offered note is never withdrawn.
        if (note_ready) begin
          tick_cnt_d = cur_ticks;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (tick_en) begin
          if (tick_cnt_q <= 12'd1) begin
            tick_cnt_d = 12'd0;
            if (notes_left_q != 3'd0) begin
              notes_left_d = notes_left_q - 3'd1;
              note_idx_d   = note_idx_q + 3'd1;
              state_d      = play ? StIssue : StPause;
            end else begin
              if (addr_q == LastAddrW) begin
                addr_d = 8'd0;
                wrap_d = 1'b1;
              end else begin
                addr_d = addr_q + 8'd1;
              end
              state_d = play ? StFetchId : StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q - 12'd1;
          end
        end
      end
      StPause: begin
        if (play) state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= 8'd0;
      rom_id_q     <= 4'd0;
      bank_q       <= 1'b0;
      phrase_q     <= 32'd0;
      len_q        <= 8'd0;
      notes_left_q <= 3'd0;
      note_idx_q   <= 3'd0;
      tick_cnt_q   <= 12'd0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rom_id_q     <= rom_id_d;
      bank_q       <= bank_d;
      phrase_q     <= phrase_d;
      len_q        <= len_d;
      notes_left_q <= notes_left_d;
      note_idx_q   <= note_idx_d;
      tick_cnt_q   <= tick_cnt_d;
      wrap_q       <= wrap_d;
    end
  end

  always_comb begin
    phrase_addr    = addr_q;
    rom_phrase_id  = rom_id_q;
    bank           = bank_q;
    note_valid     = (state_q == StIssue);
    note_freq_addr = note_valid ? cur_freq : 4'd0;
    note_ticks     = note_valid ? cur_ticks : 12'd0;
    busy           = (state_q != StIdle) && (state_q != StPause);
    song_wrap      = wrap_q;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus pushes expected notes, a negedge monitor
// pops and compares on every accepted handshake. A second instance with short tick
// constants runs the address space to the wrap point.
module tb_note_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, play, tick_en, note_ready;
  logic [4:0]  phrase_id;
  logic [31:0] phrase_data;
  logic [7:0]  length_bits;
  logic [2:0]  n_notes;
  logic [7:0]  phrase_addr;
  logic [3:0]  rom_phrase_id, note_freq_addr;
  logic        bank, note_valid, busy, song_wrap;
  logic [11:0] note_ticks;

  note_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .tick_en       (tick_en),
    .phrase_addr   (phrase_addr),
    .phrase_id     (phrase_id),
    .rom_phrase_id (rom_phrase_id),
    .bank          (bank),
    .phrase_data   (phrase_data),
    .length_bits   (length_bits),
    .n_notes       (n_notes),
    .note_valid    (note_valid),
    .note_ready    (note_ready),
    .note_freq_addr(note_freq_addr),
    .note_ticks    (note_ticks),
    .busy          (busy),
    .song_wrap     (song_wrap)
  );

  logic        play_w;
  logic [7:0]  phrase_addr_w;
  logic [3:0]  rom_phrase_id_w, note_freq_addr_w;
  logic        bank_w, note_valid_w, busy_w, song_wrap_w;
  logic [11:0] note_ticks_w;

  note_sequencer #(.T16(3), .T8(5), .T4(7)) dut_w (
    .clk           (clk),
    .reset         (reset),
    .play          (play_w),
    .tick_en       (tick_en),
    .phrase_addr   (phrase_addr_w),
    .phrase_id     (5'h1A),
    .rom_phrase_id (rom_phrase_id_w),
    .bank          (bank_w),
    .phrase_data   (32'hF000_0000),
    .length_bits   (8'h00),
    .n_notes       (3'd0),
    .note_valid    (note_valid_w),
    .note_ready    (1'b1),
    .note_freq_addr(note_freq_addr_w),
    .note_ticks    (note_ticks_w),
    .busy          (busy_w),
    .song_wrap     (song_wrap_w)
  );

  typedef struct {
    logic [3:0]  freq;
    logic [11:0] ticks;
    logic        bank;
    logic [3:0]  rom;
    logic [7:0]  addr;
    int          gap;  // cycles from previous accept to this note's valid; 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc = 0;
  int   wrap_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (note_valid && !prev_valid && sb.size() > 0 && sb[0].gap != 0)
        check("note gap", cyc - last_acc, sb[0].gap);
      if (note_valid && note_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected note: freq %0d, expected none", note_freq_addr);
        end else begin
          e = sb.pop_front();
          check("note_freq_addr", note_freq_addr, e.freq);
          check("note_ticks", note_ticks, e.ticks);
          check("bank", bank, e.bank);
          check("rom_phrase_id", rom_phrase_id, e.rom);
          check("phrase_addr", phrase_addr, e.addr);
        end
        last_acc = cyc;
        acc_cnt++;
      end
      if (song_wrap_w) wrap_cnt++;
    end
    prev_valid = note_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] f, input logic [11:0] t, input logic b,
                      input logic [3:0] r, input logic [7:0] a, input int g);
    exp_t e;
    e.freq = f; e.ticks = t; e.bank = b; e.rom = r; e.addr = a; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic wait_acc(input int target);
    int b = 0;
    while (acc_cnt < target && b < 20000) begin
      tick();
      b++;
    end
    if (acc_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept timeout: accepted %0d, expected %0d", acc_cnt, target);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 20000) begin
      tick();
      b++;
    end
    check("busy drops", busy, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst phrase_addr", phrase_addr, 0);
    check("rst rom_phrase_id", rom_phrase_id, 0);
    check("rst bank", bank, 0);
    check("rst note_valid", note_valid, 0);
    check("rst note_freq_addr", note_freq_addr, 0);
    check("rst note_ticks", note_ticks, 0);
    check("rst busy", busy, 0);
    check("rst song_wrap", song_wrap, 0);
  endtask

  initial begin
    int base;
    int prev;
    int b;
    logic [11:0] t;
    reset = 1'b1; play = 1'b0; play_w = 1'b0; tick_en = 1'b1; note_ready = 1'b1;
    phrase_id = 5'h03; phrase_data = 32'h1234_5678; length_bits = 8'h80; n_notes = 3'd7;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    // Bank 0, long first note, 8 notes; also play->valid latency.
    base = acc_cnt; prev = 0;
    for (int i = 0; i < 8; i++) begin
      t = (i == 0) ? 12'd1304 : 12'd652;
      push(4'(i + 1), t, 1'b0, 4'd3, 8'd0, (i == 0) ? 0 : prev + 1);
      prev = int'(t);
    end
    play = 1'b1;
    tick(); tick();
    check("latency valid low", note_valid, 1'b0);
    tick();
    check("latency valid high", note_valid, 1'b1);
    wait_acc(base + 8);
    play = 1'b0;
    wait_idle();
    check("addr after phrase 0", phrase_addr, 1);

    // Bank 1, last note long.
    phrase_id = 5'h12; length_bits = 8'h01;
    base = acc_cnt; prev = 0;
    for (int i = 0; i < 8; i++) begin
      t = (i == 7) ? 12'd652 : 12'd326;
      push(4'(i + 1), t, 1'b1, 4'd2, 8'd1, (i == 0) ? 0 : prev + 1);
      prev = int'(t);
    end
    play = 1'b1;
    wait_acc(base + 8);
    play = 1'b0;
    wait_idle();
    check("addr after phrase 1", phrase_addr, 2);

    // Ready stall on first note, then run straight into the next phrase.
    phrase_id = 5'h03; length_bits = 8'h80; n_notes = 3'd1; note_ready = 1'b0;
    base = acc_cnt;
    push(4'd1, 12'd1304, 1'b0, 4'd3, 8'd2, 0);
    push(4'd2, 12'd652,  1'b0, 4'd3, 8'd2, 1305);
    push(4'd1, 12'd1304, 1'b0, 4'd3, 8'd3, 655);
    push(4'd2, 12'd652,  1'b0, 4'd3, 8'd3, 1305);
    play = 1'b1;
    b = 0;
    while (!note_valid && b < 50) begin
      tick();
      b++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall valid", note_valid, 1'b1);
      check("stall freq", note_freq_addr, 4'd1);
      tick();
    end
    note_ready = 1'b1;
    wait_acc(base + 4);
    play = 1'b0;
    wait_idle();
    check("addr after stall", phrase_addr, 4);

    // Pause after note 3, resume on note 4.
    length_bits = 8'h00; n_notes = 3'd7;
    base = acc_cnt;
    for (int i = 0; i < 3; i++) push(4'(i + 1), 12'd652, 1'b0, 4'd3, 8'd4, (i == 0) ? 0 : 653);
    play = 1'b1;
    wait_acc(base + 3);
    play = 1'b0;
    wait_idle();
    check("pause addr", phrase_addr, 4);
    repeat (5) tick();
    check("pause valid", note_valid, 1'b0);
    check("pause busy", busy, 1'b0);
    for (int i = 3; i < 8; i++) push(4'(i + 1), 12'd652, 1'b0, 4'd3, 8'd4, (i == 3) ? 0 : 653);
    play = 1'b1;
    wait_acc(base + 8);
    play = 1'b0;
    wait_idle();
    check("addr after pause", phrase_addr, 5);

    // Reset mid-note with about 400 ticks left.
    length_bits = 8'h80;
    base = acc_cnt;
    push(4'd1, 12'd1304, 1'b0, 4'd3, 8'd5, 0);
    play = 1'b1;
    wait_acc(base + 1);
    repeat (903) tick();
    check("busy before reset", busy, 1'b1);
    reset = 1'b1; play = 1'b0;
    tick();
    check_reset_vals();
    reset = 1'b0;
    phrase_id = 5'h12; length_bits = 8'h00; n_notes = 3'd0;
    base = acc_cnt;
    push(4'd1, 12'd326, 1'b1, 4'd2, 8'd0, 0);
    play = 1'b1;
    wait_acc(base + 1);
    play = 1'b0;
    wait_idle();
    check("addr after restart", phrase_addr, 1);
    check("scoreboard drained", sb.size(), 0);

    // Address wrap on the short-timing instance.
    play_w = 1'b1;
    b = 0;
    while (phrase_addr_w != 8'd255 && b < 4000) begin
      tick();
      b++;
    end
    check("wrap reach 255", phrase_addr_w, 255);
    check("no early wrap", wrap_cnt, 0);
    b = 0;
    while (!song_wrap_w && b < 30) begin
      tick();
      b++;
    end
    check("wrap pulse", song_wrap_w, 1'b1);
    check("wrap addr", phrase_addr_w, 0);
    tick();
    check("wrap pulse ends", song_wrap_w, 1'b0);
    play_w = 1'b0;
    repeat (20) tick();
    check("wrap pulse width", wrap_cnt, 1);
    check("main song_wrap quiet", song_wrap, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
